// File: rtl/approx_pkg.sv
// Shared types and helpers for the approximate-adder family.
package approx_pkg;

  // Counter container is wide enough for any supported CNT_W (<= 32).
  localparam int STATS_MAX_W = 32;

  function automatic int mode_w(input int width);
    return $clog2(width + 1);
  endfunction

  function automatic int clamp_k(input int mode_k, input int approx_max);
    return (mode_k > approx_max) ? approx_max : mode_k;
  endfunction

  typedef struct packed {
    logic [STATS_MAX_W-1:0] op_cnt;
    logic [STATS_MAX_W-1:0] err_cnt;
  } stats_t;

endpackage

// File: rtl/approx_adder_core.sv
// Combinational lower-part-OR approximate adder with exact-sum mismatch detection.
module approx_adder_core #(
  parameter int WIDTH  = 8,
  parameter int MODE_W = 4
) (
  input  logic [WIDTH-1:0]  a,
  input  logic [WIDTH-1:0]  b,
  input  logic              cin,
  input  logic [MODE_W-1:0] k,
  output logic [WIDTH:0]    sum,
  output logic              mismatch
);

  logic [WIDTH-1:0] lo_mask;
  logic             carry_k;
  logic [WIDTH:0]   hi_sum;
  logic [WIDTH:0]   exact;

  always_comb begin
    lo_mask = '0;
    carry_k = cin;
    for (int i = 0; i < WIDTH; i++) begin
      if (MODE_W'(i) < k) lo_mask[i] = 1'b1;
      if (MODE_W'(i + 1) == k) carry_k = a[i] & b[i];
    end
    // Masked low bits are zero in both operands, so the injected carry lands
    // at bit k and never disturbs the OR-approximated lower part.
    hi_sum   = {1'b0, a & ~lo_mask} + {1'b0, b & ~lo_mask} + ((WIDTH+1)'(carry_k) << k);
    sum      = hi_sum | {1'b0, (a | b) & lo_mask};
    exact    = {1'b0, a} + {1'b0, b} + (WIDTH+1)'(cin);
    mismatch = (sum != exact);
  end

endmodule

// File: rtl/approx_adder_pipe.sv
// Two-stage valid/ready approximate adder with per-beat K and running error statistics.
module approx_adder_pipe
  import approx_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int APPROX_MAX = 4,
  parameter int CNT_W      = 16,
  parameter int MODE_W     = mode_w(WIDTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  a,
  input  logic [WIDTH-1:0]  b,
  input  logic              cin,
  input  logic [MODE_W-1:0] mode_k,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH:0]    sum,
  output logic              mismatch,
  input  logic              clear_stats,
  output logic [CNT_W-1:0]  op_count,
  output logic [CNT_W-1:0]  err_count
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic              vld_p1, vld_p2;
  logic [WIDTH-1:0]  a_p1, b_p1;
  logic              cin_p1;
  logic [MODE_W-1:0] k_p1;
  logic [WIDTH:0]    sum_p2;
  logic              mis_p2;
  logic [WIDTH:0]    core_sum;
  logic              core_mis;
  logic [MODE_W-1:0] k_clamped;
  logic              s2_load, s1_adv, accept, consume;
  stats_t            stats_q;

  assign s2_load   = ~vld_p2 | out_ready;
  assign s1_adv    = vld_p1 & s2_load;
  assign in_ready  = ~vld_p1 | s1_adv;
  assign accept    = in_valid & in_ready;
  assign consume   = vld_p2 & out_ready;
  assign k_clamped = MODE_W'(clamp_k(int'(mode_k), APPROX_MAX));

  // ---- input -> S1 ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vld_p1 <= 1'b0;
    else if (in_ready) vld_p1 <= in_valid;
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      a_p1   <= a;
      b_p1   <= b;
      cin_p1 <= cin;
      k_p1   <= k_clamped;
    end
  end

  approx_adder_core #(
    .WIDTH  (WIDTH),
    .MODE_W (MODE_W)
  ) u_core (
    .a        (a_p1),
    .b        (b_p1),
    .cin      (cin_p1),
    .k        (k_p1),
    .sum      (core_sum),
    .mismatch (core_mis)
  );

  // ---- S1 -> S2 ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p2 <= 1'b0;
      sum_p2 <= '0;
      mis_p2 <= 1'b0;
    end else if (s2_load) begin
      vld_p2 <= vld_p1;
      if (vld_p1) begin
        sum_p2 <= core_sum;
        mis_p2 <= core_mis;
      end
    end
  end

  assign out_valid = vld_p2;
  assign sum       = sum_p2;
  assign mismatch  = mis_p2;

  // ---- S2 -> statistics ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stats_q <= '0;
    end else if (clear_stats) begin
      stats_q <= '0;
    end else if (consume) begin
      stats_q.op_cnt <= STATS_MAX_W'(sat_inc(stats_q.op_cnt[CNT_W-1:0]));
      if (mis_p2) stats_q.err_cnt <= STATS_MAX_W'(sat_inc(stats_q.err_cnt[CNT_W-1:0]));
    end
  end

  assign op_count  = stats_q.op_cnt[CNT_W-1:0];
  assign err_count = stats_q.err_cnt[CNT_W-1:0];

  generate
    if (CNT_W < STATS_MAX_W) begin : g_hi_sink
      logic unused_hi;
      assign unused_hi = ^{stats_q.op_cnt[STATS_MAX_W-1:CNT_W], stats_q.err_cnt[STATS_MAX_W-1:CNT_W]};
    end
  endgenerate

endmodule

// File: tb/tb_approx_adder_pipe.sv
// Directed bench for approx_adder_pipe at WIDTH=8, APPROX_MAX=4, CNT_W=16.
module tb_approx_adder_pipe;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] a = '0;
  logic [7:0] b = '0;
  logic       cin = 1'b0;
  logic [3:0] mode_k = '0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [8:0] sum;
  logic       mismatch;
  logic       clear_stats = 1'b0;
  logic [15:0] op_count, err_count;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  approx_adder_pipe #(
    .WIDTH      (8),
    .APPROX_MAX (4),
    .CNT_W      (16)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .a           (a),
    .b           (b),
    .cin         (cin),
    .mode_k      (mode_k),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .sum         (sum),
    .mismatch    (mismatch),
    .clear_stats (clear_stats),
    .op_count    (op_count),
    .err_count   (err_count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one beat into an empty pipe with out_ready=1 and captures the outputs.
  task automatic drive_beat(input logic [7:0] xa, input logic [7:0] xb, input logic xc,
                            input logic [3:0] xk, output logic v1, output logic v2,
                            output logic [8:0] s, output logic m);
    a = xa; b = xb; cin = xc; mode_k = xk; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    v1 = out_valid;
    tick();
    v2 = out_valid; s = sum; m = mismatch;
    tick();
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #2;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (sum !== 9'h000) begin failures++; $display("FAIL reset_sum got=%h exp=000", sum); end
    checks++; if (mismatch !== 1'b0) begin failures++; $display("FAIL reset_mismatch got=%b exp=0", mismatch); end
    checks++; if (op_count !== 16'h0) begin failures++; $display("FAIL reset_op_count got=%h exp=0000", op_count); end
    checks++; if (err_count !== 16'h0) begin failures++; $display("FAIL reset_err_count got=%h exp=0000", err_count); end
    tick(); tick();
    rst_n = 1'b1;
    tick();
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_exact();
    logic v1, v2, m;
    logic [8:0] s;
    out_ready = 1'b1;
    drive_beat(8'hFF, 8'h01, 1'b0, 4'd0, v1, v2, s, m);
    checks++; if (v1 !== 1'b0) begin failures++; $display("FAIL exact_lat1 out_valid got=%b exp=0", v1); end
    checks++; if (v2 !== 1'b1) begin failures++; $display("FAIL exact_lat2 out_valid got=%b exp=1", v2); end
    checks++; if (s !== 9'h100) begin failures++; $display("FAIL exact_sum got=%h exp=100", s); end
    checks++; if (m !== 1'b0) begin failures++; $display("FAIL exact_mismatch got=%b exp=0", m); end
    checks++; if (op_count !== 16'd1) begin failures++; $display("FAIL exact_op_count got=%0d exp=1", op_count); end
    checks++; if (err_count !== 16'd0) begin failures++; $display("FAIL exact_err_count got=%0d exp=0", err_count); end
  endtask

  task automatic test_approx();
    logic v1, v2, m;
    logic [8:0] s;
    drive_beat(8'h0F, 8'h01, 1'b0, 4'd4, v1, v2, s, m);
    checks++; if (s !== 9'h00F) begin failures++; $display("FAIL k4_or_sum got=%h exp=00F", s); end
    checks++; if (m !== 1'b1) begin failures++; $display("FAIL k4_or_mismatch got=%b exp=1", m); end
    checks++; if (err_count !== 16'd1) begin failures++; $display("FAIL k4_or_err_count got=%0d exp=1", err_count); end
    drive_beat(8'h18, 8'h08, 1'b1, 4'd4, v1, v2, s, m);
    checks++; if (s !== 9'h028) begin failures++; $display("FAIL k4_carry_sum got=%h exp=028", s); end
    checks++; if (m !== 1'b1) begin failures++; $display("FAIL k4_carry_mismatch got=%b exp=1", m); end
    drive_beat(8'h18, 8'h08, 1'b1, 4'd7, v1, v2, s, m);
    checks++; if (s !== 9'h028) begin failures++; $display("FAIL k7_clamp_sum got=%h exp=028", s); end
    checks++; if (v2 !== 1'b1) begin failures++; $display("FAIL k7_clamp_valid got=%b exp=1", v2); end
    checks++; if (op_count !== 16'd4) begin failures++; $display("FAIL approx_op_count got=%0d exp=4", op_count); end
    checks++; if (err_count !== 16'd3) begin failures++; $display("FAIL approx_err_count got=%0d exp=3", err_count); end
  endtask

  task automatic test_backpressure();
    int   idx = 1;
    int   acc = 0;
    int   exp = 1;
    logic stable = 1'b1;
    out_ready = 1'b0;
    b = 8'h00; cin = 1'b0; mode_k = 4'd0;
    for (int c = 0; c < 6; c++) begin
      a = idx[7:0]; in_valid = 1'b1;
      #1;
      if (in_ready) begin acc++; idx++; end
      if (out_valid && (sum !== 9'h001)) stable = 1'b0;
      tick();
    end
    checks++; if (acc !== 2) begin failures++; $display("FAIL bp_accepted got=%0d exp=2", acc); end
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready got=%b exp=0", in_ready); end
    checks++; if (sum !== 9'h001) begin failures++; $display("FAIL bp_held_sum got=%h exp=001", sum); end
    checks++; if (stable !== 1'b1) begin failures++; $display("FAIL bp_stable got=%b exp=1", stable); end
    out_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      in_valid = (idx <= 5);
      a = idx[7:0];
      #1;
      if (in_valid && in_ready) idx++;
      if (out_valid) begin
        checks++;
        if (sum !== 9'(exp)) begin failures++; $display("FAIL bp_order got=%h exp=%h", sum, 9'(exp)); end
        exp++;
      end
      tick();
    end
    in_valid = 1'b0;
    checks++; if (exp !== 6) begin failures++; $display("FAIL bp_delivered got=%0d exp=5", exp - 1); end
    checks++; if (op_count !== 16'd9) begin failures++; $display("FAIL bp_op_count got=%0d exp=9", op_count); end
    checks++; if (err_count !== 16'd3) begin failures++; $display("FAIL bp_err_count got=%0d exp=3", err_count); end
  endtask

  task automatic test_clear_stats();
    logic v1, v2, m;
    logic [8:0] s;
    out_ready = 1'b1;
    a = 8'h0F; b = 8'h01; cin = 1'b0; mode_k = 4'd4; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    checks++; if ((out_valid !== 1'b1) || (mismatch !== 1'b1)) begin failures++; $display("FAIL clr_pending got=%b%b exp=11", out_valid, mismatch); end
    clear_stats = 1'b1;
    tick();
    clear_stats = 1'b0;
    checks++; if (op_count !== 16'd0) begin failures++; $display("FAIL clr_op_count got=%0d exp=0", op_count); end
    checks++; if (err_count !== 16'd0) begin failures++; $display("FAIL clr_err_count got=%0d exp=0", err_count); end
    drive_beat(8'h0F, 8'h01, 1'b0, 4'd4, v1, v2, s, m);
    checks++; if (op_count !== 16'd1) begin failures++; $display("FAIL post_clr_op_count got=%0d exp=1", op_count); end
    checks++; if (err_count !== 16'd1) begin failures++; $display("FAIL post_clr_err_count got=%0d exp=1", err_count); end
  endtask

  task automatic test_saturation();
    clear_stats = 1'b1;
    tick();
    clear_stats = 1'b0;
    out_ready = 1'b1;
    a = 8'h0F; b = 8'h01; cin = 1'b0; mode_k = 4'd4; in_valid = 1'b1;
    repeat (65540) tick();
    in_valid = 1'b0;
    repeat (3) tick();
    checks++; if (op_count !== 16'hFFFF) begin failures++; $display("FAIL sat_op_count got=%h exp=FFFF", op_count); end
    checks++; if (err_count !== 16'hFFFF) begin failures++; $display("FAIL sat_err_count got=%h exp=FFFF", err_count); end
  endtask

  task automatic test_reset_midstream();
    int seen = 0;
    out_ready = 1'b0;
    b = 8'h00; cin = 1'b0; mode_k = 4'd0;
    a = 8'h21; in_valid = 1'b1;
    tick();
    a = 8'h22;
    tick();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL mid_inflight got=%b exp=1", out_valid); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL mid_out_valid got=%b exp=0", out_valid); end
    checks++; if (op_count !== 16'd0) begin failures++; $display("FAIL mid_op_count got=%h exp=0000", op_count); end
    checks++; if (err_count !== 16'd0) begin failures++; $display("FAIL mid_err_count got=%h exp=0000", err_count); end
    @(posedge clk);
    #3 rst_n = 1'b1;
    tick();
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL mid_in_ready got=%b exp=1", in_ready); end
    out_ready = 1'b1;
    repeat (5) begin
      if (out_valid) seen++;
      tick();
    end
    checks++; if (seen !== 0) begin failures++; $display("FAIL mid_stale got=%0d exp=0", seen); end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_exact();
    test_approx();
    test_backpressure();
    test_clear_stats();
    test_saturation();
    test_reset_midstream();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
